// File: rtl/pixel_frame_controller.sv
// rtl/pixel_frame_controller.sv - ERASE/EXPOSE/CONVERT/READ frame sequencer for the pixel row control bus.
// Optional build macro PIXEL_GRAY_COUNTER_EN selects a Gray-coded COUNTER broadcast.
module pixel_frame_controller #(
    parameter int PIXEL_ARRAY_HEIGHT = 8,
    parameter int PIXEL_BITS         = 8,
    parameter int ERASE_CYCLES       = 5,
    parameter int EXPOSE_CYCLES      = 255,
    parameter int READ_CYCLES        = 2,
    localparam int RW = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          START,
    input  logic                          ABORT,
    output logic                          ERASE,
    output logic                          EXPOSE,
    output logic                          CONVERT,
    output logic [PIXEL_BITS-1:0]         COUNTER,
    output logic [PIXEL_ARRAY_HEIGHT-1:0] READ,
    output logic [RW-1:0]                 ROW_ADDR,
    output logic                          ROW_VALID,
    output logic                          BUSY,
    output logic                          FRAME_DONE
);

    localparam int MAXC = (ERASE_CYCLES > EXPOSE_CYCLES)
                        ? ((ERASE_CYCLES > READ_CYCLES) ? ERASE_CYCLES : READ_CYCLES)
                        : ((EXPOSE_CYCLES > READ_CYCLES) ? EXPOSE_CYCLES : READ_CYCLES);
    localparam int TW = $clog2(MAXC + 1);
    localparam int PB = PIXEL_BITS;
    localparam int H  = PIXEL_ARRAY_HEIGHT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [PB-1:0]   r_bin;
    logic [RW-1:0]   r_row;
    logic            r_erase;
    logic            r_expose;
    logic            r_convert;
    logic [PB-1:0]   r_counter;
    logic [H-1:0]    r_read;
    logic            r_row_valid;
    logic            r_busy;
    logic            r_frame_done;

    logic [PB-1:0]   w_bin_next;
    logic            w_bin_last;

    assign w_bin_next = r_bin + PB'(1);
    assign w_bin_last = (r_bin == {PB{1'b1}});

    // Pixel latches sample COUNTER asynchronously, so Gray coding avoids multi-bit transitions.
    function automatic logic [PB-1:0] f_code(input logic [PB-1:0] b);
`ifdef PIXEL_GRAY_COUNTER_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_bin        <= '0;
            r_row        <= '0;
            r_erase      <= 1'b0;
            r_expose     <= 1'b0;
            r_convert    <= 1'b0;
            r_counter    <= '0;
            r_read       <= '0;
            r_row_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (ABORT) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_bin        <= '0;
            r_row        <= '0;
            r_erase      <= 1'b0;
            r_expose     <= 1'b0;
            r_convert    <= 1'b0;
            r_counter    <= '0;
            r_read       <= '0;
            r_row_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state <= S_ERASE;
                        r_timer <= '0;
                        r_erase <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_ERASE: begin
                    if (r_timer == TW'(ERASE_CYCLES - 1)) begin
                        r_state  <= S_EXPOSE;
                        r_timer  <= '0;
                        r_erase  <= 1'b0;
                        r_expose <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_EXPOSE: begin
                    if (r_timer == TW'(EXPOSE_CYCLES - 1)) begin
                        r_state   <= S_CONVERT;
                        r_timer   <= '0;
                        r_expose  <= 1'b0;
                        r_convert <= 1'b1;
                        r_bin     <= '0;
                        r_counter <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_CONVERT: begin
                    if (w_bin_last) begin
                        r_state     <= S_READ;
                        r_convert   <= 1'b0;
                        r_bin       <= '0;
                        r_counter   <= '0;
                        r_timer     <= '0;
                        r_row       <= '0;
                        r_read      <= H'(1);
                        r_row_valid <= (READ_CYCLES == 1);
                    end else begin
                        r_bin     <= w_bin_next;
                        r_counter <= f_code(w_bin_next);
                    end
                end
                S_READ: begin
                    if (r_timer == TW'(READ_CYCLES - 1)) begin
                        r_timer <= '0;
                        if (r_row == RW'(H - 1)) begin
                            r_state      <= S_IDLE;
                            r_row        <= '0;
                            r_read       <= '0;
                            r_row_valid  <= 1'b0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_row       <= r_row + RW'(1);
                            r_read      <= r_read << 1;
                            r_row_valid <= (READ_CYCLES == 1);
                        end
                    end else begin
                        r_timer     <= r_timer + TW'(1);
                        r_row_valid <= (r_timer == TW'(READ_CYCLES - 2));
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ERASE      = r_erase;
    assign EXPOSE     = r_expose;
    assign CONVERT    = r_convert;
    assign COUNTER    = r_counter;
    assign READ       = r_read;
    assign ROW_ADDR   = r_row;
    assign ROW_VALID  = r_row_valid;
    assign BUSY       = r_busy;
    assign FRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_pixel_frame_controller.sv
// tb/tb_pixel_frame_controller.sv - directed self-checking bench for pixel_frame_controller.
module tb_pixel_frame_controller;

    localparam int H   = 8;
    localparam int PB  = 8;
    localparam int EC  = 5;
    localparam int XC  = 10;
    localparam int RC  = 2;
    localparam int CV0 = 1 + EC + XC;
    localparam int RD0 = CV0 + (1 << PB);
    localparam int FD  = RD0 + H * RC;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          START = 1'b0;
    logic          ABORT = 1'b0;
    logic          ERASE, EXPOSE, CONVERT, ROW_VALID, BUSY, FRAME_DONE;
    logic [PB-1:0] COUNTER;
    logic [H-1:0]  READ;
    logic [2:0]    ROW_ADDR;
    logic [31:0]   outv;

    int vectors = 0;
    int miscompares = 0;

    pixel_frame_controller #(
        .PIXEL_ARRAY_HEIGHT(H), .PIXEL_BITS(PB), .ERASE_CYCLES(EC),
        .EXPOSE_CYCLES(XC), .READ_CYCLES(RC)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
        .ERASE(ERASE), .EXPOSE(EXPOSE), .CONVERT(CONVERT), .COUNTER(COUNTER),
        .READ(READ), .ROW_ADDR(ROW_ADDR), .ROW_VALID(ROW_VALID),
        .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    assign outv = {7'd0, BUSY, FRAME_DONE, ROW_VALID, ROW_ADDR, READ, COUNTER, CONVERT, EXPOSE, ERASE};

    function automatic logic [PB-1:0] code(input int i);
        logic [PB-1:0] b;
        b = PB'(i);
`ifdef PIXEL_GRAY_COUNTER_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    // Expected outputs in cycle c after the START edge (edge 0), from the frame timeline.
    function automatic logic [31:0] exp_vec(input int c);
        logic er, ex, cv, rv, dn, bz;
        logic [PB-1:0] cnt;
        logic [H-1:0] rd;
        logic [2:0] ad;
        int rr;
        er = (c >= 1 && c < 1 + EC);
        ex = (c >= 1 + EC && c < CV0);
        cv = (c >= CV0 && c < RD0);
        cnt = cv ? code(c - CV0) : '0;
        rd = '0; ad = '0; rv = 1'b0;
        if (c >= RD0 && c < FD) begin
            rr = c - RD0;
            rd = H'(1) << (rr / RC);
            ad = 3'(rr / RC);
            rv = ((rr % RC) == RC - 1);
        end
        dn = (c == FD);
        bz = (c >= 1 && c < FD);
        return {7'd0, bz, dn, rv, ad, rd, cnt, cv, ex, er};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller sets START=1 before the edge that starts the frame; checks cycles 1..FD.
    task automatic frame(input string tag, input bit hold, input bit pulse, input int stop_at, input bit do_abort);
        logic [PB-1:0] prev;
        prev = '0;
        for (int c = 1; c <= FD; c++) begin
            @(negedge CLK);
            chk(tag, outv, exp_vec(c));
`ifdef PIXEL_GRAY_COUNTER_EN
            if (c > CV0 && c < RD0) chk({tag, "_gray1bit"}, 32'($countones(COUNTER ^ prev)), 32'd1);
            prev = COUNTER;
`endif
            if (c == stop_at) begin
                if (do_abort) ABORT = 1'b1;
                return;
            end
            START = hold || (pulse && c >= 100 && c <= 110);
        end
    endtask

    initial begin
        // Reset held with START toggling
        for (int i = 0; i < 4; i++) begin
            START = i[0];
            @(negedge CLK);
            chk("reset_hold", outv, 32'd0);
        end
        START = 1'b0;
        RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("idle_after_reset", outv, 32'd0);
        end

        // Single frame, START pulse ignored during CONVERT
        START = 1'b1;
        frame("frame1", 1'b0, 1'b1, 0, 1'b0);
        @(negedge CLK);
        chk("idle_after_frame1", outv, 32'd0);

        // START held: back-to-back frames with one idle (FRAME_DONE) cycle between
        START = 1'b1;
        frame("b2b_a", 1'b1, 1'b0, 0, 1'b0);
        frame("b2b_b", 1'b0, 1'b0, 0, 1'b0);
        @(negedge CLK);
        chk("idle_after_b2b", outv, 32'd0);

        // ABORT in cycle 100, mid-CONVERT
        START = 1'b1;
        frame("abort_pre", 1'b0, 1'b0, 100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            ABORT = 1'b0;
            chk("abort_idle", outv, 32'd0);
        end
        // ABORT beats START in IDLE
        START = 1'b1;
        ABORT = 1'b1;
        @(negedge CLK);
        chk("abort_beats_start", outv, 32'd0);
        ABORT = 1'b0;
        frame("after_abort", 1'b0, 1'b0, 0, 1'b0);

        // Reset asserted during row 3 read window
        @(negedge CLK);
        START = 1'b1;
        frame("reset_pre", 1'b0, 1'b0, RD0 + 3 * RC, 1'b0);
        START = 1'b0;
        #1 RESET_N = 1'b0;
        #1 chk("async_reset", outv, 32'd0);
        @(negedge CLK);
        chk("reset_low", outv, 32'd0);
        RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("idle_after_midreset", outv, 32'd0);
        end
        START = 1'b1;
        frame("after_reset", 1'b0, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
